instr_feeder: RTL
=================

# instr_feeder

Producer side of the cpu instruction-load interface. Deserializes 9-bit instruction words from a single-pin bit stream, buffers them in a small FIFO, and issues them to the cpu core as INSTRUCTION plus a one-cycle WRITE_EN strobe per word while RUN is high. It sits between the top-level input pins and the cpu core, so the core can be loaded from a narrow pin budget.

## Interface

- WIDTH, 9: instruction word width; matches the cpu INSTRUCTION port.
- DEPTH, 8: FIFO entries; power of two, at least 2.

- CLK, input, 1: single clock; all state on its rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- SER_DATA, input, 1: serial instruction bit, MSB first.
- SER_VALID, input, 1: SER_DATA is sampled on any edge where SER_VALID=1.
- FLUSH, input, 1: synchronous clear of FIFO, deserializer and FSM.
- RUN, input, 1: enables issuing to the core.
- INSTRUCTION, output, WIDTH: registered word presented to the cpu.
- WRITE_EN, output, 1: registered strobe, high exactly one cycle per issued word.
- FULL, output, 1: COUNT==DEPTH.
- EMPTY, output, 1: COUNT==0.
- COUNT, output, log2(DEPTH)+1: current FIFO occupancy.
- OVERFLOW, output, 1: sticky flag, set when a completed word is dropped.

## Operation

- Reset (RESET_N=0, async): INSTRUCTION=0, WRITE_EN=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0. The FSM goes to IDLE, the bit counter to 0, the shift register to 0, and the FIFO pointers to 0.
- Deserializer: WIDTH-bit shift register plus a 0..WIDTH-1 bit counter.
  - Each SER_VALID edge shifts SER_DATA in at the LSB.
  - On the edge that samples bit WIDTH-1, the completed word {shift[WIDTH-2:0], SER_DATA} is pushed and the counter returns to 0.
- Push rules:
  - If the FIFO is not full, or a pop happens on the same edge, the word is written and COUNT adjusts by net push/pop.
  - Otherwise the word is dropped, OVERFLOW is set to 1, and FIFO contents stay unchanged.
  - OVERFLOW clears only on reset or FLUSH.
- FIFO: circular buffer with log2(DEPTH)-bit read/write pointers; pointers wrap DEPTH-1 -> 0. A simultaneous push and pop leaves COUNT unchanged.
- FSM states:
  - IDLE: WRITE_EN<=0. Go to ISSUE if RUN=1 and EMPTY=0.
  - ISSUE, with RUN=1 and EMPTY=0: pop the head, INSTRUCTION<=head, WRITE_EN<=1, stay in ISSUE.
  - ISSUE, with RUN=0 or EMPTY=1: WRITE_EN<=0, go to IDLE.
- INSTRUCTION holds the last issued word until the next pop. It never changes without WRITE_EN.
- FLUSH=1 (lower priority than reset, higher than everything else):
  - COUNT=0, pointers=0, bit counter=0, OVERFLOW=0, WRITE_EN<=0, FSM=IDLE. INSTRUCTION is unchanged.
  - SER_VALID on the same edge is ignored.
- Reset asserted mid-word or mid-burst discards the partial word and all buffered words immediately.

## Timing

- Word acceptance: COUNT increments on the edge sampling the last bit. EMPTY/FULL/COUNT are combinational from registered state and are valid right after that edge.
- Issue latency:
  - With RUN=1 and a word arriving into an empty FIFO on edge k, the FSM enters ISSUE on edge k+1.
  - WRITE_EN=1 with the word on INSTRUCTION after edge k+2.
- Burst: in ISSUE, back-to-back words give WRITE_EN high on consecutive cycles, one word per cycle.
- Stop: RUN sampled low on edge j means no pop at j. WRITE_EN is low after j.
- Minimum serial word time is WIDTH cycles, so the issue rate always exceeds the fill rate. OVERFLOW only occurs when RUN=0.

## Test plan

- Reset: pulse RESET_N low mid-stream -> all outputs at reset values asynchronously, before the next CLK edge; COUNT=0, EMPTY=1.
- Single word: RUN=1, shift 9'h1A5 MSB-first with SER_VALID every cycle -> COUNT=1 at bit 9, then exactly one WRITE_EN pulse 2 cycles later with INSTRUCTION=9'h1A5; COUNT back to 0.
- Fill and overflow: RUN=0, shift 9 words 9'h001..9'h009 -> FULL=1 after the 8th, 9th dropped, OVERFLOW=1; raise RUN -> 8 consecutive WRITE_EN pulses carrying 001..008 in order; EMPTY=1 afterwards, OVERFLOW still 1.
- Wrap-around: alternate pushing 3 and issuing 3 words for 4 rounds (12 words, pointers wrap) -> issued sequence exactly matches pushed order.
- RUN drop mid-burst: 4 words buffered, RUN low after 2 pulses -> COUNT=2 held, no WRITE_EN; RUN high again -> remaining 2 words issued in order.
- FLUSH: 5 words buffered, partial word of 4 bits, OVERFLOW=1, assert FLUSH one cycle -> COUNT=0, OVERFLOW=0, no WRITE_EN. A freshly shifted 9'h0FF is then issued correctly, proving the bit counter was cleared.

Source files
------------

// File: rtl/instr_feeder_if.sv
// instr_feeder_if
//   Bundles the serial load stream, run/flush controls and the core-side
//   issue/status signals of the instruction feeder.
//   Parameters: WIDTH (instruction word width), DEPTH (FIFO entries).
//   master modport: drives SER_DATA, SER_VALID, FLUSH, RUN and observes
//                   INSTRUCTION, WRITE_EN, FULL, EMPTY, COUNT, OVERFLOW.
//   slave modport:  the feeder itself (mirror of master).
interface instr_feeder_if #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
);
    logic                     SER_DATA;
    logic                     SER_VALID;
    logic                     FLUSH;
    logic                     RUN;
    logic [WIDTH-1:0]         INSTRUCTION;
    logic                     WRITE_EN;
    logic                     FULL;
    logic                     EMPTY;
    logic [$clog2(DEPTH):0]   COUNT;
    logic                     OVERFLOW;

    modport master (
        output SER_DATA, SER_VALID, FLUSH, RUN,
        input  INSTRUCTION, WRITE_EN, FULL, EMPTY, COUNT, OVERFLOW
    );

    modport slave (
        input  SER_DATA, SER_VALID, FLUSH, RUN,
        output INSTRUCTION, WRITE_EN, FULL, EMPTY, COUNT, OVERFLOW
    );
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder
//   Deserializes WIDTH-bit instruction words (MSB first) from a single-pin
//   stream, buffers them in a DEPTH-entry FIFO and issues them to the cpu
//   core as INSTRUCTION plus a one-cycle WRITE_EN strobe while RUN is high.
//   Ports:
//     CLK      - single clock, rising edge
//     RESET_N  - asynchronous active-low reset
//     bus      - instr_feeder_if.slave: SER_DATA/SER_VALID serial input,
//                FLUSH synchronous clear, RUN issue enable, INSTRUCTION and
//                WRITE_EN to the core, FULL/EMPTY/COUNT/OVERFLOW status.
module instr_feeder #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    instr_feeder_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [WIDTH-1:0]   instruction;
    logic               write_en;
    logic               write_en_next;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               word_done;
    logic               push_ok;
    logic [WIDTH-1:0]   word_in;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // The completing bit is appended directly so the word is pushed on the
    // same edge that samples it.
    assign word_in   = {shift_reg[WIDTH-2:0], bus.SER_DATA};
    assign word_done = bus.SER_VALID && !bus.FLUSH && (bit_cnt == LAST_BIT);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push_ok   = word_done && (!fifo_full || pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.RUN && !fifo_empty) state_next = ISSUE;
            ISSUE:   if (!bus.RUN || fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.FLUSH) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        pop           = 1'b0;
        write_en_next = 1'b0;
        if (state == ISSUE && bus.RUN && !fifo_empty && !bus.FLUSH) begin
            pop           = 1'b1;
            write_en_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bus.FLUSH) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bus.SER_VALID) begin
            shift_reg <= word_in;
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.FLUSH) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (word_done && !push_ok) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instruction <= '0;
            write_en    <= 1'b0;
        end else begin
            write_en <= write_en_next;
            if (pop) instruction <= mem[rd_ptr];
        end
    end

    assign bus.INSTRUCTION = instruction;
    assign bus.WRITE_EN    = write_en;
    assign bus.FULL        = fifo_full;
    assign bus.EMPTY       = fifo_empty;
    assign bus.COUNT       = count;
    assign bus.OVERFLOW    = overflow;
endmodule
